// File: rtl/line_window_gen_pkg.sv
// Shared constants, state encoding and window-count helper for the line window generator.
package line_window_gen_pkg;

    localparam int PIX_W = 8;
    localparam int ROW_W = 3 * PIX_W;
    localparam int IDX_W = 16;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Number of full 3x3 windows in a w x h frame.
    function automatic int win_count(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/line_window_gen_line_ram.sv
// Single-clock simple dual-port line buffer, synchronous read returning the old word on
// a same-address collision. The read register only updates on re, so it holds while the
// pipeline is stalled.
module line_ram #(
    parameter  int DEPTH = 256,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clka,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata
);

    logic [W-1:0] mem [DEPTH];

    // Read-before-write port pair; no reset so it maps onto block RAM.
    always_ff @(posedge clka) begin
        if (re) rdata <= mem[raddr];
        if (we) mem[waddr] <= wdata;
    end

endmodule

// File: rtl/line_window_gen.sv
// Streams raster pixels through two line buffers and emits 3x3 windows as three packed
// row words plus a linear window index. S1 = line buffer read, S2 = window register.
module line_window_gen #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = line_window_gen_pkg::PIX_W
) (
    input  logic                                clka,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [PIX_W-1:0]                    in_pix,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [3*PIX_W-1:0]                  win_top,
    output logic [3*PIX_W-1:0]                  win_mid,
    output logic [3*PIX_W-1:0]                  win_bot,
    output logic [line_window_gen_pkg::IDX_W-1:0] win_idx,
    output logic                                frame_done
);
    import line_window_gen_pkg::*;

    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int NWIN = win_count(IMG_W, IMG_H);

    state_t              state, state_nx;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic                s1_vld, s1_win, s1_new;
    logic [PIX_W-1:0]    s1_pix;
    logic [CW-1:0]       s1_col;
    logic [PIX_W-1:0]    ram0_q, ram1_q;
    logic [2*PIX_W-1:0]  top_sr, mid_sr, bot_sr;
    logic [IDX_W-1:0]    idx_cnt;
    logic                accept, s2_free, s1_adv, col_last, row_last, pipe_empty, rearm;

    assign s2_free    = !out_valid || out_ready;
    assign s1_adv     = s1_vld && s2_free;
    assign accept     = in_valid && in_ready;
    assign col_last   = (col == CW'(IMG_W - 1));
    assign row_last   = (row == RW'(IMG_H - 1));
    assign pipe_empty = !s1_vld && !out_valid;
    assign rearm      = (state == DONE) && start && pipe_empty;
    assign frame_done = out_valid && out_ready && (win_idx == IDX_W'(NWIN - 1));

    // State register.
    always_ff @(posedge clka) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    // Leave RUN on the frame's last pixel; re-arm only once the pipeline has drained.
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (accept && col_last && row_last) state_nx = DONE;
            DONE:    if (rearm) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // Input accepted only while running and S1 is empty or being drained into S2.
    always_comb begin
        in_ready = 1'b0;
        if (!rst && state == RUN && (!s1_vld || s2_free)) in_ready = 1'b1;
    end

    // Raster position of the next pixel; row holds at the last row once DONE is reached.
    always_ff @(posedge clka) begin
        if (rst || rearm) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_last) begin
                col <= '0;
                if (!row_last) row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // S1: carries the pixel alongside the line buffer read issued at accept time.
    always_ff @(posedge clka) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_win <= 1'b0;
            s1_new <= 1'b0;
            s1_pix <= '0;
            s1_col <= '0;
        end else begin
            s1_new <= accept;
            if (accept) begin
                s1_vld <= 1'b1;
                s1_win <= (row >= RW'(2)) && (col >= CW'(2));
                s1_pix <= in_pix;
                s1_col <= col;
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end
        end
    end

    // Row r-1 buffer: read old word and write the new pixel at the same column.
    line_ram #(.DEPTH(IMG_W), .W(PIX_W)) u_ram0 (
        .clka  (clka),
        .re    (accept),
        .raddr (col),
        .rdata (ram0_q),
        .we    (accept),
        .waddr (col),
        .wdata (in_pix)
    );

    // Row r-2 buffer: the old row r-1 word is written back one cycle after its read,
    // which cannot collide with the next read since consecutive columns always differ.
    line_ram #(.DEPTH(IMG_W), .W(PIX_W)) u_ram1 (
        .clka  (clka),
        .re    (accept),
        .raddr (col),
        .rdata (ram1_q),
        .we    (s1_new),
        .waddr (s1_col),
        .wdata (ram0_q)
    );

    // S2: shift the column history on every S1 transfer; register a window when valid.
    always_ff @(posedge clka) begin
        if (rst) begin
            out_valid <= 1'b0;
            win_top   <= '0;
            win_mid   <= '0;
            win_bot   <= '0;
            win_idx   <= '0;
            idx_cnt   <= '0;
            top_sr    <= '0;
            mid_sr    <= '0;
            bot_sr    <= '0;
        end else begin
            if (rearm) idx_cnt <= '0;
            if (s1_adv) begin
                top_sr    <= {top_sr[PIX_W-1:0], ram1_q};
                mid_sr    <= {mid_sr[PIX_W-1:0], ram0_q};
                bot_sr    <= {bot_sr[PIX_W-1:0], s1_pix};
                out_valid <= s1_win;
                if (s1_win) begin
                    win_top <= {top_sr, ram1_q};
                    win_mid <= {mid_sr, ram0_q};
                    win_bot <= {bot_sr, s1_pix};
                    win_idx <= idx_cnt;
                    idx_cnt <= idx_cnt + IDX_W'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench for line_window_gen on a 7x5 image: reset values, latency, window
// contents against a ramp model, stalls, input gaps, DONE behaviour, re-arm and mid-frame reset.
module tb_line_window_gen;

    localparam int W    = 7;
    localparam int H    = 5;
    localparam int NWIN = (W - 2) * (H - 2);

    logic        clka = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_pix = '0;
    logic        in_ready, out_valid, frame_done;
    logic [23:0] win_top, win_mid, win_bot;
    logic [15:0] win_idx;

    int tests = 0, fails = 0, cyc = 0;
    int seed = 0, exp_idx = 0, fd_cnt = 0, first_cyc = 0, acc0_cyc = 0;
    int or_mode = 0, gaps = 0;
    logic [23:0] first_top = '0, first_mid = '0, first_bot = '0;
    logic        stalled = 1'b0;
    logic [23:0] h_top = '0, h_mid = '0, h_bot = '0;
    logic [15:0] h_idx = '0;

    line_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clka       (clka),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pix     (in_pix),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .win_top    (win_top),
        .win_mid    (win_mid),
        .win_bot    (win_bot),
        .win_idx    (win_idx),
        .frame_done (frame_done)
    );

    initial forever #5 clka = ~clka;

    always @(posedge clka) cyc <= cyc + 1;

    // out_ready: 0 = always take, 1 = random 50%, 2 = hold off
    initial forever begin
        @(posedge clka);
        #3;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    function automatic logic [7:0] px(input int r, input int c);
        return 8'(r * 16 + c + seed);
    endfunction

    function automatic logic [23:0] row_word(input int r, input int c);
        return {px(r, c), px(r, c + 1), px(r, c + 2)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Window monitor: every handshaken window is checked against the ramp model.
    initial forever begin : mon
        int wr, wc;
        @(negedge clka);
        if (!rst) begin
            if (stalled) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_top", 32'(win_top), 32'(h_top));
                chk("stall_mid", 32'(win_mid), 32'(h_mid));
                chk("stall_bot", 32'(win_bot), 32'(h_bot));
                chk("stall_idx", 32'(win_idx), 32'(h_idx));
            end
            if (out_valid && out_ready) begin
                wr = exp_idx / (W - 2);
                wc = exp_idx % (W - 2);
                chk("win_idx", 32'(win_idx), 32'(exp_idx));
                chk("win_top", 32'(win_top), 32'(row_word(wr, wc)));
                chk("win_mid", 32'(win_mid), 32'(row_word(wr + 1, wc)));
                chk("win_bot", 32'(win_bot), 32'(row_word(wr + 2, wc)));
                chk("frame_done", 32'(frame_done), 32'(exp_idx == NWIN - 1));
                if (exp_idx == 0) begin
                    first_cyc = cyc;
                    first_top = win_top;
                    first_mid = win_mid;
                    first_bot = win_bot;
                end
                if (frame_done) fd_cnt++;
                exp_idx++;
            end else begin
                chk("frame_done_idle", 32'(frame_done), 32'd0);
            end
            stalled = out_valid && !out_ready;
            h_top = win_top;
            h_mid = win_mid;
            h_bot = win_bot;
            h_idx = win_idx;
        end else begin
            stalled = 1'b0;
        end
    end

    // Offer one pixel and wait (bounded) for it to be taken; entered and left at posedge+2.
    task automatic send(input int r, input int c);
        int n = 0;
        if (gaps != 0 && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            @(posedge clka);
            #2;
        end
        in_valid = 1'b1;
        in_pix   = px(r, c);
        @(negedge clka);
        while (!in_ready && n < 50) begin
            @(negedge clka);
            n++;
        end
        if (n >= 50) chk("in_ready_wait", 32'(in_ready), 32'd1);
        if (r == 0 && c == 0) acc0_cyc = cyc;
        @(posedge clka);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic send_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(r, c);
    endtask

    task automatic wait_windows();
        int n = 0;
        while (exp_idx < NWIN && n < 300) begin
            @(posedge clka);
            n++;
        end
        repeat (4) @(posedge clka);
        #2;
        chk("window_count", 32'(exp_idx), 32'(NWIN));
        chk("frame_done_count", 32'(fd_cnt), 32'd1);
    endtask

    initial begin
        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clka);
        @(negedge clka);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_win_top", 32'(win_top), 32'd0);
        chk("rst_win_bot", 32'(win_bot), 32'd0);
        chk("rst_win_idx", 32'(win_idx), 32'd0);
        @(posedge clka);
        #2;
        rst = 1'b0;
        @(negedge clka);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // start while running has no effect
        @(posedge clka);
        #2;
        start = 1'b1;
        @(posedge clka);
        #2;
        start = 1'b0;

        // Frame 1: no stalls, no gaps
        seed = 0; exp_idx = 0; fd_cnt = 0; gaps = 0; or_mode = 0;
        send_frame();
        wait_windows();
        chk("f1_first_top", 32'(first_top), 32'h000102);
        chk("f1_first_mid", 32'(first_mid), 32'h101112);
        chk("f1_first_bot", 32'(first_bot), 32'h202122);
        chk("f1_latency", 32'(first_cyc - acc0_cyc), 32'(2 + 2 * W + 2));

        // DONE: input ignored
        in_valid = 1'b1;
        in_pix   = 8'hAA;
        repeat (3) begin
            @(negedge clka);
            chk("done_in_ready", 32'(in_ready), 32'd0);
            chk("done_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clka);
        #2;
        in_valid = 1'b0;
        chk("done_no_extra", 32'(exp_idx), 32'(NWIN));

        // Re-arm, then frame 2 with random stalls and input gaps
        start = 1'b1;
        @(posedge clka);
        #2;
        start = 1'b0;
        @(negedge clka);
        chk("rearm_in_ready", 32'(in_ready), 32'd1);
        @(posedge clka);
        #2;
        exp_idx = 0; fd_cnt = 0; gaps = 1; or_mode = 1;
        send_frame();
        or_mode = 2;
        repeat (2) @(posedge clka);
        @(negedge clka);
        chk("held_last_window", 32'(out_valid), 32'd1);
        @(posedge clka);
        #2;
        start = 1'b1;
        @(posedge clka);
        #2;
        start = 1'b0;
        @(negedge clka);
        chk("busy_start_ignored", 32'(in_ready), 32'd0);
        @(posedge clka);
        #2;
        or_mode = 1;
        wait_windows();

        // Frame 3: reset at row 3 col 4, then a fresh frame with new data
        or_mode = 0; gaps = 0;
        start = 1'b1;
        @(posedge clka);
        #2;
        start = 1'b0;
        exp_idx = 0; fd_cnt = 0; seed = 40;
        for (int r = 0; r <= 3; r++)
            for (int c = 0; c < W; c++)
                if (r < 3 || c <= 4) send(r, c);
        rst = 1'b1;
        chk("abort_no_frame_done", 32'(fd_cnt), 32'd0);
        exp_idx = 0; seed = 77;
        @(posedge clka);
        @(negedge clka);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_win_idx", 32'(win_idx), 32'd0);
        @(posedge clka);
        #2;
        rst = 1'b0;
        @(negedge clka);
        chk("abort_rearm_in_ready", 32'(in_ready), 32'd1);
        @(posedge clka);
        #2;
        send_frame();
        wait_windows();
        chk("f3_first_top", 32'(first_top), 32'h4D4E4F);
        chk("f3_first_mid", 32'(first_mid), 32'h5D5E5F);
        chk("f3_first_bot", 32'(first_bot), 32'h6D6E6F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
